// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Widths, requester identity and round-robin reset value.
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 1 << ADDR_W;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_e;

  // M as last winner lets the ALU take the first tie.
  localparam req_e RR_RST = REQ_M;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bit per register, set at issue,
// cleared at write; query muxes and sticky protocol error.
module rf_scoreboard #(
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREG   = rf_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic              chk_en,
  input  logic [ADDR_W-1:0] chk_rd,
  input  logic [ADDR_W-1:0] qa,
  input  logic [ADDR_W-1:0] qb,
  output logic              busy_a,
  output logic              busy_b,
  output logic              err
);
  import rf_pkg::*;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            set_ok;
  logic            waw;
  logic            orphan;

  assign set_ok = set_en && (set_rd != '0);

  // Clear first, then set: a newer issue beats the retiring write.
  always_comb begin
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[clr_rd] = 1'b0;
    if (set_ok)
      busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign waw = set_ok && busy[set_rd]
            && !(clr_en && (clr_rd == set_rd));

  assign orphan = chk_en && (chk_rd != '0)
               && !busy[chk_rd];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      err  <= err | waw | orphan;
    end
  end

  assign busy_a = busy[qa];
  assign busy_b = busy[qb];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter between ALU and LSU writeback onto the single
// register-file write port, with a registered write stage.
module rf_wb_arbiter #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREG   = rf_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_rd,
  input  logic [DATA_W-1:0] m_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] qa,
  input  logic [ADDR_W-1:0] qb,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_din,
  output logic              err
);
  import rf_pkg::*;

  req_e              rr_last;
  logic              grant;
  logic              g_live;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;

  always_comb begin
    a_ready = 1'b0;
    m_ready = 1'b0;
    if (reset) begin
      unique case (1'b1)
        (a_valid && m_valid): begin
          a_ready = (rr_last == REQ_M);
          m_ready = (rr_last == REQ_A);
        end
        (a_valid && !m_valid): a_ready = 1'b1;
        (!a_valid && m_valid): m_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign grant  = a_ready | m_ready;
  assign g_rd   = m_ready ? m_rd : a_rd;
  assign g_data = m_ready ? m_data : a_data;
  // x0 writes are accepted but never reach the file.
  assign g_live = grant && (g_rd != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last <= RR_RST;
      rf_we   <= 1'b0;
      rf_rw   <= '0;
      rf_din  <= '0;
    end else begin
      rf_we <= g_live;
      if (g_live) begin
        rf_rw  <= g_rd;
        rf_din <= g_data;
      end
      if (grant)
        rr_last <= m_ready ? REQ_M : REQ_A;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (iss_valid),
    .set_rd (iss_rd),
    .clr_en (rf_we),
    .clr_rd (rf_rw),
    .chk_en (grant),
    .chk_rd (g_rd),
    .qa     (qa),
    .qb     (qb),
    .busy_a (busy_a),
    .busy_b (busy_b),
    .err    (err)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic,
// all checked against a behavioural model of the writeback rules.
module tb_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, a_ready, m_valid, m_ready;
  logic [AW-1:0] a_rd, m_rd, iss_rd, qa, qb, rf_rw;
  logic [DW-1:0] a_data, m_data, rf_din;
  logic          iss_valid, busy_a, busy_b, rf_we, err;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_rd(a_rd), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_rd(m_rd), .m_data(m_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .qa(qa), .qb(qb),
    .busy_a(busy_a), .busy_b(busy_b),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_din(rf_din),
    .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // model state
  bit          mb[NR];
  bit          last_m;
  bit          m_we;
  logic [AW-1:0] m_rw;
  logic [DW-1:0] m_din;
  bit          m_err;
  bit          lga, lgm;

  function automatic void mreset();
    foreach (mb[i]) mb[i] = 1'b0;
    last_m = 1'b1;
    m_we = 1'b0;
    m_rw = '0;
    m_din = '0;
    m_err = 1'b0;
  endfunction

  // Lone requester wins; on a tie the one that did not win last.
  function automatic void arb(output bit ga, output bit gm);
    ga = 1'b0;
    gm = 1'b0;
    if (reset) begin
      if (a_valid && m_valid) begin
        ga = last_m;
        gm = !last_m;
      end else begin
        ga = a_valid;
        gm = m_valid;
      end
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic settle();
    bit ga, gm;
    #1;
    if (!reset) mreset();
    arb(ga, gm);
    chk("a_ready", 32'(a_ready), 32'(ga));
    chk("m_ready", 32'(m_ready), 32'(gm));
    chk("busy_a", 32'(busy_a), 32'(mb[qa]));
    chk("busy_b", 32'(busy_b), 32'(mb[qb]));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("err", 32'(err), 32'(m_err));
    if (m_we) begin
      chk("rf_rw", 32'(rf_rw), 32'(m_rw));
      chk("rf_din", rf_din, m_din);
    end
  endtask

  task automatic tick();
    bit ga, gm;
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    @(posedge clk);
    lga = 1'b0;
    lgm = 1'b0;
    if (!reset) begin
      mreset();
    end else begin
      arb(ga, gm);
      lga = ga;
      lgm = gm;
      rd = gm ? m_rd : a_rd;
      d  = gm ? m_data : a_data;
      if (iss_valid && iss_rd != 0 && mb[iss_rd]
          && !(m_we && m_rw == iss_rd))
        m_err = 1'b1;
      if ((ga || gm) && rd != 0 && !mb[rd])
        m_err = 1'b1;
      if (m_we) mb[m_rw] = 1'b0;
      if (iss_valid && iss_rd != 0) mb[iss_rd] = 1'b1;
      m_we = (ga || gm) && rd != 0;
      if (m_we) begin
        m_rw = rd;
        m_din = d;
      end
      if (ga || gm) last_m = gm;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    a_valid = 0; a_rd = 0; a_data = 0;
    m_valid = 0; m_rd = 0; m_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic issue(logic [AW-1:0] r);
    iss_valid = 1; iss_rd = r;
    settle(); tick();
    iss_valid = 0;
  endtask

  task automatic rst_pulse();
    idle();
    reset = 0; settle(); tick();
    reset = 1;
  endtask

  bit pa, pm;

  initial begin
    reset = 0; qa = 0; qb = 0;
    idle();
    mreset();
    @(negedge clk);

    // reset holds readies low
    a_valid = 1; a_rd = 1; qa = 1; qb = 2;
    settle();
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_busy", 32'({busy_a, busy_b}), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    reset = 1;
    a_rd = 0; m_valid = 1; m_rd = 0;
    settle();
    chk("first_tie_a", 32'(a_ready), 1);
    chk("first_tie_m", 32'(m_ready), 0);
    tick();
    idle();

    // single write
    qa = 5;
    issue(5);
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    settle();
    chk("sw_ready", 32'(a_ready), 1);
    chk("sw_busy0", 32'(busy_a), 1);
    tick();
    idle();
    settle();
    chk("sw_we", 32'(rf_we), 1);
    chk("sw_rw", 32'(rf_rw), 5);
    chk("sw_din", rf_din, 32'hDEADBEEF);
    chk("sw_busy1", 32'(busy_a), 1);
    tick();
    settle();
    chk("sw_busy2", 32'(busy_a), 0);
    tick();

    // contention
    rst_pulse();
    qa = 3; qb = 7;
    issue(3);
    issue(7);
    a_valid = 1; a_rd = 3; a_data = 32'h11;
    m_valid = 1; m_rd = 7; m_data = 32'h22;
    settle();
    chk("ct_a1", 32'(a_ready), 1);
    chk("ct_m1", 32'(m_ready), 0);
    tick();
    a_valid = 0;
    settle();
    chk("ct_m2", 32'(m_ready), 1);
    chk("ct_rw1", 32'(rf_rw), 3);
    chk("ct_din1", rf_din, 32'h11);
    tick();
    m_valid = 0;
    settle();
    chk("ct_we2", 32'(rf_we), 1);
    chk("ct_rw2", 32'(rf_rw), 7);
    chk("ct_din2", rf_din, 32'h22);
    tick();
    settle();
    chk("ct_clear", 32'({busy_a, busy_b}), 0);
    tick();

    // set/clear collision
    qa = 9;
    issue(9);
    a_valid = 1; a_rd = 9; a_data = 32'h99;
    settle(); tick();
    a_valid = 0;
    iss_valid = 1; iss_rd = 9;
    settle();
    chk("col_rw", 32'(rf_rw), 9);
    tick();
    iss_valid = 0;
    settle();
    chk("col_busy", 32'(busy_a), 1);
    chk("col_err", 32'(err), 0);
    a_valid = 1; a_rd = 9; a_data = 32'h9A;
    settle(); tick();
    a_valid = 0;
    settle(); tick();
    settle();
    chk("col_done", 32'(busy_a), 0);

    // x0 and violations
    m_valid = 1; m_rd = 0; m_data = 32'h55;
    settle();
    chk("x0_ready", 32'(m_ready), 1);
    tick();
    m_valid = 0;
    settle();
    chk("x0_we", 32'(rf_we), 0);
    chk("x0_err", 32'(err), 0);
    tick();
    issue(4);
    issue(4);
    settle();
    chk("waw_err", 32'(err), 1);
    tick(); tick();
    settle();
    chk("waw_sticky", 32'(err), 1);
    tick();

    // reset mid-operation
    rst_pulse();
    qa = 6;
    issue(6);
    a_valid = 1; a_rd = 6; a_data = 32'h66;
    settle(); tick();
    a_valid = 0;
    settle();
    chk("mid_we", 32'(rf_we), 1);
    reset = 0;
    settle();
    chk("mid_we_rst", 32'(rf_we), 0);
    chk("mid_busy", 32'(busy_a), 0);
    chk("mid_err", 32'(err), 0);
    tick();
    reset = 1;
    settle();
    chk("mid_lost", 32'(rf_we), 0);
    tick();

    // random traffic
    pa = 0; pm = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!pa && $urandom_range(0, 1) == 1) begin
        pa = 1;
        a_rd = AW'($urandom_range(0, 7));
        a_data = $urandom;
      end
      if (!pm && $urandom_range(0, 1) == 1) begin
        pm = 1;
        m_rd = AW'($urandom_range(0, 7));
        m_data = $urandom;
      end
      a_valid = pa;
      m_valid = pm;
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_rd = AW'($urandom_range(0, 7));
      qa = AW'($urandom_range(0, 7));
      qb = AW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 99) != 0);
      settle();
      tick();
      if (lga) pa = 0;
      if (lgm) pm = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the register file's single write port (we/rw/Din) between two writeback requesters: ALU/execute (port a) and load/store unit (port m).
- Fair round-robin arbitration and a registered write stage.
- Keeps a per-register pending-write scoreboard, so issue logic can detect RAW/WAW hazards on the register file read ports.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- NREG, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  ALU writeback request.
- a_ready  out  1  ALU request accepted this cycle.
- a_rd  in  ADDR_W  ALU destination register.
- a_data  in  DATA_W  ALU result.
- m_valid  in  1  LSU writeback request.
- m_ready  out  1  LSU request accepted this cycle.
- m_rd  in  ADDR_W  LSU destination register.
- m_data  in  DATA_W  load data.
- iss_valid  in  1  an instruction writing iss_rd is issued.
- iss_rd  in  ADDR_W  destination of the issued instruction.
- qa  in  ADDR_W  scoreboard query A (mirrors register file ra).
- qb  in  ADDR_W  scoreboard query B (mirrors register file rb).
- busy_a  out  1  qa has a pending write.
- busy_b  out  1  qb has a pending write.
- rf_we  out  1  to register file we.
- rf_rw  out  ADDR_W  to register file rw.
- rf_din  out  DATA_W  to register file Din.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset=0, asynchronous): rf_we=0, rf_rw=0, rf_din=0, busy[NREG-1:0]=0, rr_last=M (so ALU wins the first tie), err=0. An in-flight write stage is discarded. a_ready and m_ready are 0 while reset is asserted.
- Handshake: a request transfers in a cycle where valid&ready=1. ready is combinational from valid and rr_last and does not depend on data. A requester holds valid/rd/data stable until accepted.
- Arbitration: at most one grant per cycle.
  - Only one of a_valid/m_valid high: that one is granted.
  - Both high: grant the one not equal to rr_last.
  - rr_last updates only on a grant.
  - No grant: rr_last holds.
- Write stage: one registered stage.
  - A grant in cycle N drives rf_we=1, rf_rw=rd, rf_din=data during cycle N+1.
  - The register file captures the write at the end of N+1. The new value is readable in N+2.
  - No grant in N: rf_we=0 in N+1; rf_rw and rf_din hold their last values.
- x0: a granted request with rd=0 is accepted (ready=1) but produces rf_we=0. The scoreboard is not touched.
- Scoreboard:
  - iss_valid with iss_rd!=0 sets busy[iss_rd] at the clock edge.
  - rf_we=1 clears busy[rf_rw] at the end of that cycle.
  - Set and clear of the same register in the same cycle: set wins (newer instruction).
  - busy[0] is constant 0.
  - busy_a=busy[qa] and busy_b=busy[qb], combinational.
- Protocol checks (err sets and stays 1 until reset):
  - iss_valid with iss_rd!=0 while busy[iss_rd]=1 and not being cleared this cycle (WAW overlap).
  - A granted writeback whose rd!=0 has busy[rd]=0 (write without issue).
  - The offending operation still proceeds.
- Latency: request to rf_we is 1 cycle. Request to busy clear is visible 2 cycles later. Throughput is 1 write per cycle. Worst-case wait for a continuously valid requester is 1 cycle.

Decomposition:
- Shared package rf_pkg: ADDR_W, DATA_W, NREG, the requester enum {REQ_A, REQ_M}, and the reset value of rr_last.
- One natural sub-module: rf_scoreboard. It holds the busy vector, set/clear priority, query muxes and WAW check. The arbiter and write stage stay in the top module.

Test Plan:
- Reset: hold reset=0 with a_valid=1 -> a_ready=0, rf_we=0, busy_a=busy_b=0, err=0; release -> first grant goes to ALU.
- Single write:
  - Stimulus: iss rd=5; next cycle a_valid, a_rd=5, a_data=0xDEADBEEF.
  - Required: a_ready=1; next cycle rf_we=1, rf_rw=5, rf_din=0xDEADBEEF; busy_a(qa=5) is 1 until the cycle after rf_we, then 0.
- Contention:
  - Stimulus: issue rd 3 and rd 7; hold a_valid (rd=3, 0x11) and m_valid (rd=7, 0x22) together.
  - Required: cycle 1 grants A; cycle 2 grants M; rf writes 3/0x11 then 7/0x22 on consecutive cycles; no request waits more than 1 cycle.
- Set/clear collision:
  - Stimulus: rd=9 pending and being written (rf_we=1, rf_rw=9) in the same cycle that iss_valid, iss_rd=9.
  - Required: busy[9] stays 1; err stays 0.
- x0 and violations:
  - m_valid with rd=0 -> m_ready=1, rf_we=0, err=0.
  - iss rd=4 twice without an intervening write -> err=1 and stays 1 until reset.
- Reset mid-operation: grant in cycle N, assert reset in N+1 -> rf_we=0 immediately, busy cleared, write lost.
